// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one byte-addressed data memory between the processor
// data port (port 0) and the debug/program-loader port (port 1).
// Round-robin arbitration with optional locked bursts of up to MAX_BURST
// grants; one access per cycle, with no idle cycle between grants.
//
// Optional build macro: DMEM_ARB_STATS_EN adds the saturating per-port grant
// and wait counters (grant_cnt0/1, wait_cnt0/1).
//
// state  | meaning
// IDLE   | no access this cycle; all memory-side outputs are 0
// GRANT0 | port 0 owns the memory this cycle (ack0 = 1)
// GRANT1 | port 1 owns the memory this cycle (ack1 = 1)
module dmem_arbiter #(
  parameter int MEM_BYTES = 1024,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1,
  output logic [15:0] wait_cnt0,
  output logic [15:0] wait_cnt1,
`endif
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  // A one-deep burst still needs a 1-bit counter so the ports stay legal.
  localparam int              CNT_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [31:0]      ADDR_MAX   = 32'(MEM_BYTES - 4);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             last_grant;
  logic             last_grant_nxt;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_cnt_nxt;
  logic             cont0;
  logic             cont1;

  // A locked owner keeps the memory until its burst budget is spent.
  assign cont0 = (state == GRANT0) && req0 && lock0 && (burst_cnt < BURST_LAST);
  assign cont1 = (state == GRANT1) && req1 && lock1 && (burst_cnt < BURST_LAST);

  // Next grant: locked continuation first, then round-robin, then lone requester.
  always_comb begin
    state_nxt      = IDLE;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = '0;
    if (cont0) begin
      state_nxt     = GRANT0;
      burst_cnt_nxt = burst_cnt + CNT_W'(1);
    end else if (cont1) begin
      state_nxt     = GRANT1;
      burst_cnt_nxt = burst_cnt + CNT_W'(1);
    end else if (req0 && req1) begin
      state_nxt = last_grant ? GRANT0 : GRANT1;
    end else if (req0) begin
      state_nxt = GRANT0;
    end else if (req1) begin
      state_nxt = GRANT1;
    end
    if (state_nxt == GRANT0) begin
      last_grant_nxt = 1'b0;
    end else if (state_nxt == GRANT1) begin
      last_grant_nxt = 1'b1;
    end
  end

  // Arbitration state; reset makes port 0 win the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  // Memory-side outputs decode the registered state only, so a reset drops
  // the grant (and any pending write strobe) in the very next cycle.
  always_comb begin
    ack0      = (state == GRANT0);
    ack1      = (state == GRANT1);
    err0      = ack0 && (addr0 > ADDR_MAX);
    err1      = ack1 && (addr1 > ADDR_MAX);
    mem_addr  = '0;
    mem_wdata = '0;
    if (ack0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (ack1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
    mem_we = (ack0 && we0 && !err0) || (ack1 && we1 && !err1);
    rdata0 = ack0 ? mem_rdata : '0;
    rdata1 = ack1 ? mem_rdata : '0;
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating per-port activity counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      wait_cnt0  <= '0;
      wait_cnt1  <= '0;
    end else begin
      if (ack0 && (grant_cnt0 != 16'hFFFF)) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (ack1 && (grant_cnt1 != 16'hFFFF)) grant_cnt1 <= grant_cnt1 + 16'd1;
      if (req0 && !ack0 && (wait_cnt0 != 16'hFFFF)) wait_cnt0 <= wait_cnt0 + 16'd1;
      if (req1 && !ack1 && (wait_cnt1 != 16'hFFFF)) wait_cnt1 <= wait_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios followed by randomized request traffic,
// checked cycle by cycle against a behavioural model of the arbitration rules
// and a byte-array model of the data memory.
module tb_dmem_arbiter;

  localparam int MEM_BYTES = 1024;
  localparam int MAX_BURST = 4;
  localparam int ARR_BYTES = 1040;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err0, err1, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1, wait_cnt0, wait_cnt1;
`endif

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
`ifdef DMEM_ARB_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
    .wait_cnt0(wait_cnt0), .wait_cnt1(wait_cnt1),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // environment memory (what the arbiter drives) and the bench's expected copy
  byte unsigned dmem    [ARR_BYTES];
  byte unsigned ref_mem [ARR_BYTES];

  always_comb begin
    mem_rdata = '0;
    if (int'(mem_addr) + 3 < ARR_BYTES)
      mem_rdata = {dmem[mem_addr+3], dmem[mem_addr+2], dmem[mem_addr+1], dmem[mem_addr]};
  end

  always @(negedge clk) begin
    if (mem_we && (int'(mem_addr) + 3 < ARR_BYTES)) begin
      dmem[mem_addr]   = mem_wdata[7:0];
      dmem[mem_addr+1] = mem_wdata[15:8];
      dmem[mem_addr+2] = mem_wdata[23:16];
      dmem[mem_addr+3] = mem_wdata[31:24];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int i;
    i = int'(a);
    if (a < 32'(ARR_BYTES - 3))
      return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
    return '0;
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d);
    int i;
    i = int'(a);
    ref_mem[i]   = d[7:0];
    ref_mem[i+1] = d[15:8];
    ref_mem[i+2] = d[23:16];
    ref_mem[i+3] = d[31:24];
  endtask

  // reference arbitration model: owner of the current cycle, grants so far in
  // the current locked run, and the most recent winner
  int g = -1;
  int m_chain = 0;
  int m_last = 1;
  int sc_g[2] = '{0, 0};
  int sc_w[2] = '{0, 0};

  task automatic tick_edge();
    bit sr0, sr1, sl0, sl1, srst;
    int pg;
    sr0 = req0; sr1 = req1; sl0 = lock0; sl1 = lock1; srst = reset; pg = g;
    @(posedge clk);
    #1;
    if (!srst) begin
      g = -1; m_chain = 0; m_last = 1;
      sc_g = '{0, 0}; sc_w = '{0, 0};
    end else begin
      if (pg == 0) sc_g[0] = (sc_g[0] < 65535) ? sc_g[0] + 1 : sc_g[0];
      else if (sr0) sc_w[0] = (sc_w[0] < 65535) ? sc_w[0] + 1 : sc_w[0];
      if (pg == 1) sc_g[1] = (sc_g[1] < 65535) ? sc_g[1] + 1 : sc_g[1];
      else if (sr1) sc_w[1] = (sc_w[1] < 65535) ? sc_w[1] + 1 : sc_w[1];
      if (g >= 0 && (g == 0 ? (sr0 && sl0) : (sr1 && sl1)) && m_chain < MAX_BURST) begin
        m_chain++;
      end else begin
        if (sr0 && sr1) g = 1 - m_last;
        else if (sr0)   g = 0;
        else if (sr1)   g = 1;
        else            g = -1;
        m_chain = (g >= 0) ? 1 : 0;
      end
      if (g >= 0) m_last = g;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] a, wd, exp_rd;
    logic        w, e;
    #1;
    chk("ack0", ack0, 32'(g == 0));
    chk("ack1", ack1, 32'(g == 1));
    if (g < 0) begin
      chk("idle_mem_addr", mem_addr, 32'h0);
      chk("idle_mem_wdata", mem_wdata, 32'h0);
      chk("idle_mem_we", mem_we, 32'h0);
      chk("idle_err", {err1, err0}, 32'h0);
      chk("idle_rdata0", rdata0, 32'h0);
      chk("idle_rdata1", rdata1, 32'h0);
    end else begin
      a  = (g == 0) ? addr0 : addr1;
      wd = (g == 0) ? wdata0 : wdata1;
      w  = (g == 0) ? we0 : we1;
      e  = (a > 32'(MEM_BYTES - 4));
      exp_rd = ref_rd(a);
      chk("mem_addr", mem_addr, a);
      chk("mem_wdata", mem_wdata, wd);
      chk("mem_we", mem_we, 32'(w && !e));
      chk("err0", err0, 32'(g == 0 && e));
      chk("err1", err1, 32'(g == 1 && e));
      chk("rdata0", rdata0, (g == 0) ? exp_rd : 32'h0);
      chk("rdata1", rdata1, (g == 1) ? exp_rd : 32'h0);
      if (w && !e) ref_wr(a, wd);
    end
  endtask

  task automatic tick();
    tick_edge();
    check_outputs();
  endtask

  task automatic check_stats();
`ifdef DMEM_ARB_STATS_EN
    chk("grant_cnt0", 32'(grant_cnt0), 32'(sc_g[0]));
    chk("grant_cnt1", 32'(grant_cnt1), 32'(sc_g[1]));
    chk("wait_cnt0", 32'(wait_cnt0), 32'(sc_w[0]));
    chk("wait_cnt1", 32'(wait_cnt1), 32'(sc_w[1]));
`endif
  endtask

  task automatic reset_pulse();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic new_payload(input int n);
    logic [31:0] a;
    a = ($urandom_range(0, 4) == 0) ? 32'(1017 + $urandom_range(0, 12))
                                    : 32'(4 * $urandom_range(0, 15));
    if (n == 0) begin
      addr0 = a; we0 = 1'($urandom); wdata0 = $urandom; lock0 = 1'($urandom);
    end else begin
      addr1 = a; we1 = 1'($urandom); wdata1 = $urandom; lock1 = 1'($urandom);
    end
  endtask

  bit keep[2];

  initial begin
    for (int i = 0; i < ARR_BYTES; i++) begin
      dmem[i]    = 8'($urandom);
      ref_mem[i] = dmem[i];
    end

    // reset held with both ports requesting
    req0 = 1; req1 = 1; addr0 = 32'h40; addr1 = 32'h44;
    tick();
    tick();
    reset = 1;
    tick();
    chk("first_grant_port0", ack0, 32'h1);
    req0 = 0;
    tick();
    req1 = 0;
    tick();

    // lone store then load from the same address
    req0 = 1; we0 = 1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
    tick();
    chk("store_ack", ack0, 32'h1);
    tick_edge();
    we0 = 0;
    check_outputs();
    chk("load_data", rdata0, 32'hDEADBEEF);
    req0 = 0;
    tick();

    // unlocked contention strictly alternates
    reset_pulse();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h20; addr1 = 32'h24;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("alternate", {ack1, ack0}, (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    req0 = 0; req1 = 0;
    tick();

    // locked burst from port 0 yields after MAX_BURST grants
    reset_pulse();
    req0 = 1; req1 = 1; lock0 = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("burst", {ack1, ack0}, (i == MAX_BURST) ? 32'h2 : 32'h1);
    end
    req0 = 0; req1 = 0; lock0 = 0;
    tick();

    // out-of-range store is acked, flagged and suppressed
    req0 = 1; we0 = 1; addr0 = 32'd1020; wdata0 = 32'hA5A5A5A5;
    tick();
    req0 = 0;
    req1 = 1; we1 = 1; addr1 = 32'd1021; wdata1 = 32'h12345678;
    tick();
    chk("oor_ack1", ack1, 32'h1);
    chk("oor_err1", err1, 32'h1);
    chk("oor_mem_we", mem_we, 32'h0);
    req1 = 0;
    req0 = 1; we0 = 0; addr0 = 32'd1020;
    tick();
    chk("oor_top_word_kept", rdata0, 32'hA5A5A5A5);
    req0 = 0;
    tick();

    // reset at the second grant of a locked burst
    reset_pulse();
    req0 = 1; req1 = 1; lock0 = 1; we0 = 0; we1 = 0;
    tick();
    tick();
    chk("burst_second_grant", ack0, 32'h1);
    reset = 0;
    tick();
    chk("reset_drops_grant", {ack1, ack0}, 32'h0);
    check_stats();
    reset = 1; req0 = 0; req1 = 0; lock0 = 0;
    tick();

    // randomized traffic obeying the hold-until-ack handshake
    reset_pulse();
    keep = '{0, 0};
    for (int c = 0; c < 1500; c++) begin
      tick_edge();
      for (int n = 0; n < 2; n++) begin
        if (keep[n]) begin
          new_payload(n);
        end else if (((n == 0) ? req0 : req1) == 1'b0 && $urandom_range(0, 2) == 0) begin
          new_payload(n);
          if (n == 0) req0 = 1; else req1 = 1;
        end
      end
      check_outputs();
      keep = '{0, 0};
      if (g >= 0) begin
        keep[g] = 1'($urandom);
        if (!keep[g]) begin
          if (g == 0) req0 = 0; else req1 = 0;
        end
      end
    end
    check_stats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single byte-addressed data_memory between the processor data port (port 0) and a debug/program-loader port (port 1).
- Sits between the requesters and data_memory and drives its address, write_data and write_enable.
- Round-robin arbitration with optional locked bursts; one access per cycle, with no bubble between grants.

Parameters:
- MEM_BYTES, 1024, size of the data memory in bytes; legal word addresses are 0..MEM_BYTES-4.
- MAX_BURST, 4, maximum number of consecutive locked grants to one port before it must yield.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- req0, req1  in  1  access request, ports 0 and 1.
- lock0, lock1  in  1  port requests to keep the grant for its next access.
- we0, we1  in  1  1 = store word, 0 = load word.
- addr0, addr1  in  32  byte address.
- wdata0, wdata1  in  32  store data.
- ack0, ack1  out  1  access performed this cycle.
- rdata0, rdata1  out  32  load data, valid while ackN = 1.
- err0, err1  out  1  address out of range; valid with ackN.
- mem_addr  out  32  to data_memory address.
- mem_wdata  out  32  to data_memory write_data.
- mem_we  out  1  to data_memory write_enable.
- mem_rdata  in  32  from data_memory read_data (combinational read).

Behaviour:
- FSM states: IDLE, GRANT0, GRANT1. State register, last_grant (1 bit) and burst_cnt ($clog2(MAX_BURST) bits) are updated on posedge clk.
- Reset (reset == 0 at posedge):
  - state = IDLE, last_grant = 1 (port 0 wins the first tie), burst_cnt = 0.
  - Consequently ack0/1 = 0, err0/1 = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, rdata0/1 = 0.
  - A reset mid-burst drops the grant immediately; no partial write occurs, because mem_we is decoded from state.
- Outputs (pure decodes of the registered state):
  - ackN = (state == GRANTN).
  - mem_addr / mem_wdata = addrN / wdataN of the granted port; 0 in IDLE.
  - mem_we = weN & ackN & ~errN.
  - rdataN = mem_rdata when ackN, else 0.
  - errN = ackN & (addrN > MEM_BYTES-4). The access is acked but the write is suppressed, and the read returns mem_rdata unchanged.
- Handshake:
  - A requester raises reqN with addr/we/wdata and holds them stable until the cycle in which ackN = 1.
  - The access completes in the ackN cycle; data_memory writes on the negedge inside that cycle.
  - If reqN is still high in the ackN cycle, it is a new request with the new address, sampled at the next posedge.
  - Latency: minimum 1 cycle from req sampled to ack.
- Next-state logic, evaluated at each posedge using current req/lock:
  - Locked continuation: if state == GRANTN, reqN & lockN & (burst_cnt < MAX_BURST-1), stay in GRANTN and increment burst_cnt.
  - Otherwise, with both requesting: grant the port != last_grant.
  - Otherwise, with one requesting: grant that port.
  - Otherwise: go to IDLE.
  - On entering or re-entering GRANTN: last_grant = N. burst_cnt resets to 0 whenever the granted port changes or the FSM passes through IDLE.
- Unlocked simultaneous requests strictly alternate 0,1,0,1.
- A lone requester is granted every cycle it requests.
- Burst boundary: after MAX_BURST consecutive locked grants, port N yields if the other port requests. If the other port is idle, N is re-granted with burst_cnt = 0.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, add outputs:
  - grant_cnt0 and grant_cnt1 (16 bits each): ackN cycles.
  - wait_cnt0 and wait_cnt1 (16 bits each): cycles with reqN = 1 & ackN = 0.
  - Counters saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset held low for 2 cycles with req0 = req1 = 1 -> ack0 = ack1 = 0 and mem_we = 0 throughout. First cycle after release: ack0 = 1.
- Lone request: req0 = 1, we0 = 1, addr0 = 0x10, wdata0 = 0xDEADBEEF for 1 cycle, then a load from 0x10 -> 1-cycle latency on each; the load returns rdata0 = 0xDEADBEEF.
- Contention: req0 = req1 = 1 continuously, both unlocked, 6 accesses -> ack sequence 0,1,0,1,0,1 with no idle cycle.
- Locked burst: MAX_BURST = 4, lock0 = 1, req0 = req1 = 1 -> ack0 for 4 consecutive cycles, then ack1 for 1 cycle, then ack0 again.
- Out of range: req1 = 1, we1 = 1, addr1 = 1021 (MEM_BYTES = 1024) -> ack1 = 1, err1 = 1, mem_we = 0, and memory bytes 1020..1023 are unchanged.
- Reset during a locked burst at its second grant -> the next cycle is IDLE with no ack. Under DMEM_ARB_STATS_EN, all counters read 0 afterwards.
